// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bsadd.sv
// Bit-serial add/subtract: one full-adder slice plus a carry flop, one result bit per clock.
// Subtraction is A + ~B + 1, with the +1 injected through the initial carry.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for START; last result held on S/CO/V
//   ST_SHIFT | one bit step per clock, LSB first, WIDTH steps
//   ST_DONE  | single-cycle completion pulse; START here restarts
module gf180mcu_fd_sc_mcu9t5v0__bsadd #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             V
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic             cmsb;
    logic             last_step;
    logic [WIDTH-1:0] res_next;
    logic             accept;

    assign fa_sum    = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_cout   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // On the final step the carry register holds the carry into the MSB.
    assign cmsb      = carry;
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign res_next  = {fa_sum, res_sr};
    assign accept    = START && ((state == ST_IDLE) || (state == ST_DONE));

    assign BUSY = (state == ST_SHIFT);
    assign DONE = (state == ST_DONE);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            CO     <= 1'b0;
            V      <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[WIDTH-1:1];
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        state <= ST_DONE;
                        S     <= res_next;
                        CO    <= fa_cout;
                        V     <= fa_cout ^ cmsb;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= ST_SHIFT;
                        a_sr  <= A;
                        b_sr  <= SUB ? ~B : B;
                        carry <= SUB;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bsadd.sv
// Scoreboard bench for the bit-serial adder: stimulus pushes expected results,
// a negedge monitor pops and compares whenever DONE is presented.
module tb_gf180mcu_fd_sc_mcu9t5v0__bsadd;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         v;
    } exp_t;

    logic         CLK;
    logic         RN;
    logic         START;
    logic         SUB;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] S;
    logic         CO;
    logic         V;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    gf180mcu_fd_sc_mcu9t5v0__bsadd #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RN   (RN),
        .START(START),
        .SUB  (SUB),
        .A    (A),
        .B    (B),
        .BUSY (BUSY),
        .DONE (DONE),
        .S    (S),
        .CO   (CO),
        .V    (V)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RN && DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_s", 32'(S), 32'(e.s));
                chk("result_co", 32'(CO), 32'(e.co));
                chk("result_v", 32'(V), 32'(e.v));
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        e.s  = full[W-1:0];
        e.co = full[W];
        e.v  = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge where DONE is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input exp_t e, input bit chk_busy);
        int n;
        int busy_cnt;
        START = 1'b1; A = a; B = b; SUB = sub;
        sb.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        A = ~a; B = ~b; SUB = ~sub;
        n = 0;
        busy_cnt = 0;
        while (!DONE && n < 20) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            n++;
        end
        if (!DONE) chk("done_timeout", 32'd0, 32'd1);
        if (chk_busy) chk("busy_cycles", 32'(busy_cnt), 32'(W));
    endtask

    initial begin
        exp_t e;
        int   n;
        RN = 1'b0; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
        #12;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_co", 32'(CO), 32'd0);
        chk("rst_v", 32'(V), 32'd0);
        @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);

        // Directed vectors with hand-computed results.
        run_op(8'h5A, 8'h3C, 1'b0, '{s: 8'h96, co: 1'b0, v: 1'b1}, 1'b1);
        repeat (3) @(negedge CLK);
        chk("hold_s_idle", 32'(S), 32'h96);
        chk("hold_v_idle", 32'(V), 32'd1);
        run_op(8'hFF, 8'h01, 1'b0, '{s: 8'h00, co: 1'b1, v: 1'b0}, 1'b1);
        @(negedge CLK);
        run_op(8'h10, 8'h20, 1'b1, '{s: 8'hF0, co: 1'b0, v: 1'b0}, 1'b1);
        @(negedge CLK);
        run_op(8'h80, 8'h01, 1'b1, '{s: 8'h7F, co: 1'b1, v: 1'b1}, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, '{s: 8'h00, co: 1'b1, v: 1'b0}, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0, '{s: 8'h80, co: 1'b0, v: 1'b1}, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, '{s: 8'hFF, co: 1'b0, v: 1'b0}, 1'b1);
        run_op(8'h33, 8'h44, 1'b0, '{s: 8'h77, co: 1'b0, v: 1'b0}, 1'b1);
        @(negedge CLK);

        // START held high; operands churn while busy, real operands presented in DONE cycle.
        START = 1'b1; A = 8'h5A; B = 8'h3C; SUB = 1'b0;
        sb.push_back('{s: 8'h96, co: 1'b0, v: 1'b1});
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge CLK);
                n++;
                if (!DONE) begin
                    A = W'($urandom); B = W'($urandom); SUB = 1'($urandom);
                end
            end while (!DONE && n < 30);
            chk("restart_period", 32'(n), 32'd9);
            if (k == 0) begin
                A = 8'h80; B = 8'h01; SUB = 1'b1;
                sb.push_back('{s: 8'h7F, co: 1'b1, v: 1'b1});
            end else if (k == 1) begin
                A = 8'hFF; B = 8'h01; SUB = 1'b0;
                sb.push_back('{s: 8'h00, co: 1'b1, v: 1'b0});
            end else begin
                START = 1'b0;
            end
        end
        @(negedge CLK);

        // Reset mid-operation at e4: outputs clear at once, no DONE afterwards.
        START = 1'b1; A = 8'h12; B = 8'h34; SUB = 1'b0;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RN = 1'b0;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_s", 32'(S), 32'd0);
        chk("abort_co", 32'(CO), 32'd0);
        chk("abort_v", 32'(V), 32'd0);
        repeat (2) @(negedge CLK);
        RN = 1'b1;
        repeat (12) @(negedge CLK);
        run_op(8'h12, 8'h34, 1'b0, '{s: 8'h46, co: 1'b0, v: 1'b0}, 1'b1);

        // Random sweep against the sign-rule reference model, 0-3 idle cycles between ops.
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            e  = model(ra, rb, rs);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            run_op(ra, rb, rs, e, 1'b0);
        end
        repeat (4) @(negedge CLK);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
